// File: rtl/microwave_countdown_if.sv
// microwave_countdown_if: load/control/timebase inputs and digit/status outputs of the countdown core (master drives inputs, slave is the core)
interface microwave_countdown_if;
  logic       loadn;
  logic [3:0] units_of_seconds;
  logic [3:0] tens_of_seconds;
  logic [3:0] units_of_minutes;
  logic       pgt_1Hz;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       running;
  logic       done;
  logic       done_pulse;
  modport master (
    output loadn, units_of_seconds, tens_of_seconds, units_of_minutes, pgt_1Hz, start, stop, clear,
    input  sec_ones, sec_tens, min_ones, running, done, done_pulse
  );
  modport slave (
    input  loadn, units_of_seconds, tens_of_seconds, units_of_minutes, pgt_1Hz, start, stop, clear,
    output sec_ones, sec_tens, min_ones, running, done, done_pulse
  );
endinterface

// File: rtl/microwave_countdown.sv
// microwave_countdown: BCD m:ss countdown timer (clk, rst, bus: loadn/digits/pgt_1Hz/start/stop/clear in, digits/running/done/done_pulse out)
module microwave_countdown #(
  parameter logic TICK_EDGE_RESET = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  microwave_countdown_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READY, RUN, DONE} state_t;
  state_t     state;
  logic       hist;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       running, done, done_pulse;
  logic [3:0] ld_so, ld_st, ld_mo;
  logic       tick, last;
  always_comb begin
    ld_so = bus.units_of_seconds > 4'd9 ? 4'd0 : bus.units_of_seconds;
    ld_st = bus.tens_of_seconds > 4'd9 ? 4'd0 : bus.tens_of_seconds;
    ld_mo = bus.units_of_minutes > 4'd9 ? 4'd0 : bus.units_of_minutes;
    tick  = bus.pgt_1Hz & ~hist;
    last  = min_ones == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hist       <= TICK_EDGE_RESET;
      sec_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      min_ones   <= 4'd0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      hist       <= bus.pgt_1Hz;
      done_pulse <= 1'b0;
      if (!bus.loadn) begin
        sec_ones <= ld_so;
        sec_tens <= ld_st;
        min_ones <= ld_mo;
        state    <= |{ld_so, ld_st, ld_mo} ? READY : IDLE;
        running  <= 1'b0;
        done     <= 1'b0;
      end else if (bus.clear) begin
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        state    <= IDLE;
        running  <= 1'b0;
        done     <= 1'b0;
      end else if (state == RUN && bus.stop) begin
        state   <= READY;
        running <= 1'b0;
      end else if (state == READY && bus.start) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (state == RUN && tick) begin
        if (last) begin
          sec_ones   <= 4'd0;
          state      <= DONE;
          running    <= 1'b0;
          done       <= 1'b1;
          done_pulse <= 1'b1;
        end else if (sec_ones != 4'd0) begin
          sec_ones <= sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
          sec_tens <= sec_tens - 4'd1;
          sec_ones <= 4'd9;
        end else begin
          min_ones <= min_ones - 4'd1;
          sec_tens <= 4'd5;
          sec_ones <= 4'd9;
        end
      end
    end
  end
  assign bus.sec_ones   = sec_ones;
  assign bus.sec_tens   = sec_tens;
  assign bus.min_ones   = min_ones;
  assign bus.running    = running;
  assign bus.done       = done;
  assign bus.done_pulse = done_pulse;
endmodule

// File: tb/tb_microwave_countdown.sv
// tb_microwave_countdown: scoreboard bench comparing the countdown core against a value-level reference model
module tb_microwave_countdown;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  microwave_countdown_if bus();
  microwave_countdown #(.TICK_EDGE_RESET(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int          tag;
    logic [14:0] exp;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [14:0] act;
  int mv;
  int mst;
  bit mh;
  bit mdp;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int san(input logic [3:0] d);
    return d > 4'd9 ? 0 : int'(d);
  endfunction
  task automatic step();
    bit tk;
    tk = bus.pgt_1Hz && !mh;
    if (rst) begin
      mv = 0; mst = 0; mdp = 0; mh = 1;
    end else begin
      mh = bus.pgt_1Hz;
      mdp = 0;
      if (!bus.loadn) begin
        mv = san(bus.units_of_minutes) * 100 + san(bus.tens_of_seconds) * 10 + san(bus.units_of_seconds);
        mst = mv != 0 ? 1 : 0;
      end else if (bus.clear) begin
        mv = 0; mst = 0;
      end else if (mst == 2 && bus.stop) begin
        mst = 1;
      end else if (mst == 1 && bus.start) begin
        mst = 2;
      end else if (mst == 2 && tk) begin
        if (mv == 1) begin
          mv = 0; mst = 3; mdp = 1;
        end else begin
          mv = mv % 100 == 0 ? mv - 41 : mv - 1;
        end
      end
    end
    q.push_back('{cyc + 1, {4'(mv % 10), 4'((mv / 10) % 10), 4'(mv / 100), mst == 2, mst == 3, mdp}});
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    #2;
    while (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      act = {bus.sec_ones, bus.sec_tens, bus.min_ones, bus.running, bus.done, bus.done_pulse};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL outputs cycle %0d: got so=%0d st=%0d mo=%0d run=%b done=%b dp=%b, want so=%0d st=%0d mo=%0d run=%b done=%b dp=%b",
                 cyc, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                 e.exp[14:11], e.exp[10:7], e.exp[6:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end
  task automatic steps(input int n);
    repeat (n) step();
  endtask
  task automatic load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    bus.loadn = 1'b0;
    bus.units_of_minutes = m;
    bus.tens_of_seconds = t;
    bus.units_of_seconds = o;
    step();
    bus.loadn = 1'b1;
    step();
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      bus.pgt_1Hz = 1'b1;
      step();
      bus.pgt_1Hz = 1'b0;
      step();
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    mv = 0; mst = 0; mh = 1; mdp = 0;
    rst = 1'b1;
    bus.loadn = 1'b1;
    bus.units_of_seconds = 4'd0;
    bus.tens_of_seconds = 4'd0;
    bus.units_of_minutes = 4'd0;
    bus.pgt_1Hz = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clear = 1'b0;
    #1;
    step();
    rst = 1'b0;
    steps(20);
    bus.pgt_1Hz = 1'b0;
    step();
    load(4'd1, 4'd0, 4'd5);
    pulse_start();
    ticks(6);
    load(4'd0, 4'd0, 4'd2);
    pulse_start();
    ticks(2);
    steps(2);
    pulse_start();
    steps(2);
    load(4'd0, 4'd9, 4'd0);
    pulse_start();
    ticks(90);
    load(4'hf, 4'hf, 4'hf);
    pulse_start();
    steps(2);
    load(4'd0, 4'd3, 4'd0);
    pulse_start();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    ticks(3);
    pulse_start();
    ticks(1);
    load(4'd0, 4'd4, 4'd5);
    pulse_start();
    ticks(1);
    load(4'd0, 4'd1, 4'd2);
    pulse_start();
    bus.stop = 1'b1;
    bus.pgt_1Hz = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.pgt_1Hz = 1'b0;
    step();
    bus.start = 1'b1;
    bus.pgt_1Hz = 1'b1;
    step();
    bus.start = 1'b0;
    bus.pgt_1Hz = 1'b0;
    step();
    ticks(2);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    load(4'd7, 4'd0, 4'd0);
    pulse_start();
    ticks(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(3);
    repeat (4000) begin
      rst = $urandom_range(0, 499) == 0;
      bus.loadn = $urandom_range(0, 199) != 0;
      bus.units_of_minutes = $urandom_range(0, 5) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 1));
      bus.tens_of_seconds = 4'($urandom_range(0, 15));
      bus.units_of_seconds = 4'($urandom_range(0, 15));
      bus.start = $urandom_range(0, 9) == 0;
      bus.stop = $urandom_range(0, 39) == 0;
      bus.clear = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 2) == 0) bus.pgt_1Hz = ~bus.pgt_1Hz;
      step();
    end
    rst = 1'b0;
    bus.loadn = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microwave_countdown.md
# microwave_countdown

Countdown core of the microwave timer. Loads the three BCD digits produced by the keypad timer-entry stage while its active-low load strobe is asserted, then counts down one second per rising edge of the 1 Hz timebase once started. It drives the seven-segment digit outputs, a `running` level for the magnetron/turntable control, and a `done` indication for the buzzer logic.

## Interface
Parameters:
- `TICK_EDGE_RESET`, default 1'b1: reset value of the 1 Hz edge-detect history register. With 1, a timebase that is already high at reset does not produce a tick.

Ports:
- `clk`  in  1  system clock; 100 Hz in the product.
- `rst`  in  1  synchronous, active-high reset.
- `loadn`  in  1  active-low load. Level-sensitive: digits are sampled on every clock while low.
- `units_of_seconds`  in  4  BCD digit from the entry stage.
- `tens_of_seconds`  in  4  BCD digit from the entry stage.
- `units_of_minutes`  in  4  BCD digit from the entry stage.
- `pgt_1Hz`  in  1  1 Hz timebase (square wave); only its rising edge is used.
- `start`  in  1  start request; level or pulse.
- `stop`  in  1  pause request; level or pulse.
- `clear`  in  1  clear request; level or pulse.
- `sec_ones`  out  4  current seconds units digit.
- `sec_tens`  out  4  current seconds tens digit.
- `min_ones`  out  4  current minutes digit.
- `running`  out  1  high only in state RUN.
- `done`  out  1  high only in state DONE.
- `done_pulse`  out  1  single-cycle pulse on entry to DONE.

## Operation
**Digit sanitising on load**
- Any input digit with a value of 10–15, including the blank code 4'b1111, is loaded as 0.
- `tens_of_seconds` values 6–9 are loaded as-is.

**Tick detection**
- `tick` = `pgt_1Hz` & ~`hist`.
- `hist` <= `pgt_1Hz` every cycle; it resets to `TICK_EDGE_RESET`.

**Decrement rule (one tick while in RUN)**
- If `sec_ones` > 0: decrement `sec_ones`.
- Else if `sec_tens` > 0: decrement `sec_tens`; `sec_ones` <= 9.
- Else: decrement `min_ones`; `sec_tens` <= 5; `sec_ones` <= 9.
- Consequence: a loaded tens digit above 5 counts down through its own values first. Example: 0:90 counts 90, 89, … 00.

**States**
- IDLE: count is 000.
- READY: count is nonzero, stopped.
- RUN: counting.
- DONE: count reached 000 after running.

**Priority each cycle:** `rst` > `loadn` low > `clear` > `stop` > `start` > `tick`.
- `rst`: all digits 0; state IDLE; `done_pulse` 0; `hist` = `TICK_EDGE_RESET`.
- `loadn` low, in any state: load the sanitised digits. Next state is READY if the loaded value is nonzero, otherwise IDLE. Any countdown in progress is aborted.
- `clear`: digits 0; state IDLE.
- `stop`: RUN goes to READY. Ignored in all other states.
- `start`: READY goes to RUN. Ignored in IDLE, DONE and RUN.
- `tick` in RUN:
  - Apply the decrement.
  - If the pre-decrement count was 0:0:1, go to DONE and assert `done_pulse` for the following cycle.
- Ticks outside RUN are discarded; they are not queued.
- DONE persists until `loadn` low, `clear` or `rst`.
- The count never wraps below 000.

## Timing
- Reset values: `sec_ones`, `sec_tens` and `min_ones` = 0; `running`, `done` and `done_pulse` = 0.
- All outputs are registered.
- Digit latency:
  - A digit presented with `loadn` low at edge N appears on the outputs after edge N.
  - A `pgt_1Hz` rising edge first sampled high at edge N updates the count at edge N (single-cycle latency).
- `running` rises at the edge that samples `start`, and falls at the edge that samples `stop`, `clear`, `loadn` low, or the final tick.
- `done` and `done_pulse` rise at the same edge as the count reaching 000. `done_pulse` is high for exactly one cycle.
- Simultaneous `start` and `tick` in READY: enter RUN; the tick is not applied.
- Simultaneous `stop` and `tick` in RUN: enter READY; the tick is not applied.
- `rst` asserted mid-count: all state returns to reset values at that edge.

## Test plan
- Reset with `pgt_1Hz` high, then hold 20 cycles → no decrement; outputs 0/0/0, `running`=0, `done`=0.
- Load 1:05 with `loadn` low, raise `loadn`, pulse `start`, apply 6 rising edges → count sequence 1:04, 1:03, 1:02, 1:01, 1:00, 0:59.
- Load 0:02, start, apply 2 ticks → 0:00; `done`=1; `done_pulse` high for exactly 1 cycle; `running`=0. A further `start` is ignored.
- Load 0:90 → ticks give 0:89 … 0:00 after 90 ticks. Load 1111/1111/1111 → 0:00 and state IDLE; `start` is ignored.
- Start at 0:30; pulse `stop` → `running`=0; 3 ticks leave 0:30. `start` again → `running`=1 and the next tick gives 0:29.
- Running at 0:45: `loadn` low with digits 2/1/0 → count 0:12, `running`=0. Same cycle `stop` and `tick` → READY and no decrement. Then `clear` → 0:00 IDLE. Then `rst` mid-count → all outputs 0.
